// File: rtl/sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bus_ctrl
//  Brief    : Clocked 8051 / loader to asynchronous SRAM bridge. It has
//             synchronised MCU strobes, programmable wait states, a bank
//             extension and MCU-priority arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module sram_bus_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 16,
  parameter int BANK_W   = 1,
  parameter int WAIT_CYC = 2,
  localparam int SAW     = AW + 1 + BANK_W
) (
  input  logic              clk_i,
  input  logic              mcu_rst_i,
  input  logic              mcu_cs_i,
  input  logic              mcu_wr_i,
  input  logic              mcu_rd_i,
  input  logic              mcu_psen_i,
  input  logic [AW-1:0]     mcu_addr_i,
  input  logic [DW-1:0]     mcu_wrdat_i,
  output logic [DW-1:0]     mcu_rddat_o,
  output logic              mcu_busy_o,
  output logic              mcu_ovf_o,
  input  logic [BANK_W-1:0] bank_i,
  input  logic              ld_req_i,
  input  logic              ld_wr_i,
  input  logic [SAW-1:0]    ld_addr_i,
  input  logic [DW-1:0]     ld_wrdat_i,
  output logic              ld_ack_o,
  output logic [DW-1:0]     ld_rddat_o,
  inout  wire  [DW-1:0]     sram_data_io,
  output logic [SAW-1:0]    sram_addr_o,
  output logic              sram_ce_no,
  output logic              sram_oe_no,
  output logic              sram_we_no
);

  localparam logic [3:0] C_WAIT_LAST = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Synchroniser bit order: {psen, wr, act}
  logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic           act_prev_q, act_prev_d;
  logic           mcu_pend_q, mcu_pend_d;
  logic           mcu_ovf_q, mcu_ovf_d;
  logic [SAW-1:0] mcu_addr_q, mcu_addr_d;
  logic [DW-1:0]  mcu_wdat_q, mcu_wdat_d;
  logic           mcu_wr_q, mcu_wr_d;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [SAW-1:0] acc_addr_q, acc_addr_d;
  logic [DW-1:0]  acc_wdat_q, acc_wdat_d;
  logic           acc_wr_q, acc_wr_d;
  logic           acc_mcu_q, acc_mcu_d;
  logic [DW-1:0]  mcu_rddat_q, mcu_rddat_d;
  logic [DW-1:0]  ld_rddat_q, ld_rddat_d;

  logic           w_act;
  logic           w_act_edge;
  logic           w_mcu_take;
  logic [SAW-1:0] w_cap_addr;
  logic           w_drive;

  assign w_act      = mcu_cs_i & (mcu_rd_i | mcu_wr_i | mcu_psen_i);
  assign w_act_edge = sync2_q[0] & ~act_prev_q;
  assign w_mcu_take = w_act_edge & ~mcu_pend_q;
  // Address and data are stable while the strobe is high, so they are taken
  // straight from the pins. Only the strobes need synchronising.
  assign w_cap_addr = {bank_i, sync2_q[2] & ~sync2_q[1], mcu_addr_i};

  // Strobe synchroniser, edge detect, MCU pending/overflow and request capture
  always_comb begin
    sync1_d    = {mcu_psen_i, mcu_wr_i, w_act};
    sync2_d    = sync1_q;
    act_prev_d = sync2_q[0];
    mcu_pend_d = mcu_pend_q;
    mcu_ovf_d  = mcu_ovf_q;
    mcu_addr_d = mcu_addr_q;
    mcu_wdat_d = mcu_wdat_q;
    mcu_wr_d   = mcu_wr_q;
    if (w_act_edge) begin
      if (mcu_pend_q) begin
        mcu_ovf_d = 1'b1;
      end else begin
        mcu_pend_d = 1'b1;
        mcu_addr_d = w_cap_addr;
        mcu_wdat_d = mcu_wrdat_i;
        mcu_wr_d   = sync2_q[1];
      end
    end
    if ((state_q == S_HOLD) && acc_mcu_q) begin
      mcu_pend_d = 1'b0;
    end
  end

  // Access sequencer: arbitration, wait-state counting, read-data capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_addr_d  = acc_addr_q;
    acc_wdat_d  = acc_wdat_q;
    acc_wr_d    = acc_wr_q;
    acc_mcu_d   = acc_mcu_q;
    mcu_rddat_d = mcu_rddat_q;
    ld_rddat_d  = ld_rddat_q;
    case (state_q)
      S_IDLE: begin
        if (mcu_pend_q) begin
          acc_addr_d = mcu_addr_q;
          acc_wdat_d = mcu_wdat_q;
          acc_wr_d   = mcu_wr_q;
          acc_mcu_d  = 1'b1;
          state_d    = S_SETUP;
        end else if (w_mcu_take) begin
          // The edge is seen this cycle, so the capture registers are not
          // loaded yet. Start from the same values they are about to take.
          acc_addr_d = w_cap_addr;
          acc_wdat_d = mcu_wrdat_i;
          acc_wr_d   = sync2_q[1];
          acc_mcu_d  = 1'b1;
          state_d    = S_SETUP;
        end else if (ld_req_i) begin
          acc_addr_d = ld_addr_i;
          acc_wdat_d = ld_wrdat_i;
          acc_wr_d   = ld_wr_i;
          acc_mcu_d  = 1'b0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = 4'd0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == C_WAIT_LAST) begin
          state_d = S_HOLD;
          if (!acc_wr_q) begin
            if (acc_mcu_q) mcu_rddat_d = sram_data_io;
            else           ld_rddat_d  = sram_data_io;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. Asynchronous reset drops the strobes immediately.
  always_ff @(posedge clk_i or posedge mcu_rst_i) begin
    if (mcu_rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      act_prev_q  <= 1'b0;
      mcu_pend_q  <= 1'b0;
      mcu_ovf_q   <= 1'b0;
      mcu_addr_q  <= '0;
      mcu_wdat_q  <= '0;
      mcu_wr_q    <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      acc_addr_q  <= '0;
      acc_wdat_q  <= '0;
      acc_wr_q    <= 1'b0;
      acc_mcu_q   <= 1'b0;
      mcu_rddat_q <= '0;
      ld_rddat_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      act_prev_q  <= act_prev_d;
      mcu_pend_q  <= mcu_pend_d;
      mcu_ovf_q   <= mcu_ovf_d;
      mcu_addr_q  <= mcu_addr_d;
      mcu_wdat_q  <= mcu_wdat_d;
      mcu_wr_q    <= mcu_wr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdat_q  <= acc_wdat_d;
      acc_wr_q    <= acc_wr_d;
      acc_mcu_q   <= acc_mcu_d;
      mcu_rddat_q <= mcu_rddat_d;
      ld_rddat_q  <= ld_rddat_d;
    end
  end

  // SRAM controls are decoded from state only. oe_n and we_n cannot be low
  // together because acc_wr_q selects exactly one of them.
  assign w_drive      = acc_wr_q & (state_q != S_IDLE);
  assign sram_data_io = w_drive ? acc_wdat_q : {DW{1'bz}};
  assign sram_addr_o  = acc_addr_q;
  assign sram_ce_no   = (state_q == S_IDLE);
  assign sram_oe_no   = ~((state_q == S_STROBE) & ~acc_wr_q);
  assign sram_we_no   = ~((state_q == S_STROBE) & acc_wr_q);

  assign mcu_rddat_o  = mcu_rddat_q;
  assign ld_rddat_o   = ld_rddat_q;
  assign ld_ack_o     = (state_q == S_HOLD) & ~acc_mcu_q;
  assign mcu_busy_o   = mcu_pend_q | ((state_q != S_IDLE) & acc_mcu_q);
  assign mcu_ovf_o    = mcu_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_bus_ctrl
//  Brief    : Directed self-checking bench for sram_bus_ctrl with a
//             behavioural asynchronous SRAM on the data bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mcu_cs = 0, mcu_wr = 0, mcu_rd = 0, mcu_psen = 0;
  logic [15:0] mcu_addr = '0;
  logic [7:0]  mcu_wrdat = '0;
  logic [7:0]  mcu_rddat;
  logic        mcu_busy, mcu_ovf;
  logic [0:0]  bank = '0;
  logic        ld_req = 0, ld_wr = 0;
  logic [17:0] ld_addr = '0;
  logic [7:0]  ld_wrdat = '0;
  logic        ld_ack;
  logic [7:0]  ld_rddat;
  wire  [7:0]  sram_data;
  logic [17:0] sram_addr;
  logic        ce_n, oe_n, we_n;

  int n_cmp = 0;
  int n_err = 0;

  sram_bus_ctrl #(.DW(8), .AW(16), .BANK_W(1), .WAIT_CYC(2)) dut (
    .clk_i(clk), .mcu_rst_i(rst),
    .mcu_cs_i(mcu_cs), .mcu_wr_i(mcu_wr), .mcu_rd_i(mcu_rd), .mcu_psen_i(mcu_psen),
    .mcu_addr_i(mcu_addr), .mcu_wrdat_i(mcu_wrdat), .mcu_rddat_o(mcu_rddat),
    .mcu_busy_o(mcu_busy), .mcu_ovf_o(mcu_ovf), .bank_i(bank),
    .ld_req_i(ld_req), .ld_wr_i(ld_wr), .ld_addr_i(ld_addr), .ld_wrdat_i(ld_wrdat),
    .ld_ack_o(ld_ack), .ld_rddat_o(ld_rddat),
    .sram_data_io(sram_data), .sram_addr_o(sram_addr),
    .sram_ce_no(ce_n), .sram_oe_no(oe_n), .sram_we_no(we_n)
  );

  always #5 clk = ~clk;

  // Undriven bus reads back as 8'hFF.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup pu (sram_data[gi]);
  end

  // Behavioural SRAM
  logic [7:0] mem [0:(1<<18)-1];
  assign sram_data = (!ce_n && !oe_n) ? mem[sram_addr] : 8'bz;
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_data;

  // Bus monitors, sampled on the falling edge
  int          we_cnt, oe_cnt, ce_cnt, ack_cnt, acc_cnt, both_low, drv_seen, hi_run;
  logic        ce_prev = 1'b1;
  logic [17:0] log_addr [0:15];
  int          log_gap  [0:15];
  always @(negedge clk) begin
    if (!we_n) we_cnt++;
    if (!oe_n) oe_cnt++;
    if (!ce_n) ce_cnt++;
    if (ld_ack) ack_cnt++;
    if (!we_n && !oe_n) both_low++;
    if (oe_n && we_n && sram_data !== 8'hFF) drv_seen++;
    if (ce_n) hi_run++;
    else if (ce_prev) begin
      if (acc_cnt < 16) begin
        log_addr[acc_cnt] = sram_addr;
        log_gap[acc_cnt]  = hi_run;
      end
      acc_cnt++;
      hi_run = 0;
    end
    ce_prev = ce_n;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    we_cnt = 0; oe_cnt = 0; ce_cnt = 0; ack_cnt = 0; acc_cnt = 0;
    both_low = 0; drv_seen = 0; hi_run = 0;
  endtask

  task automatic mcu_drive(input logic wr, input logic rd, input logic psen,
                           input logic [15:0] a, input logic [7:0] d, input logic b);
    mcu_cs = 1; mcu_wr = wr; mcu_rd = rd; mcu_psen = psen;
    mcu_addr = a; mcu_wrdat = d; bank = b;
  endtask

  task automatic mcu_release();
    mcu_cs = 0; mcu_wr = 0; mcu_rd = 0; mcu_psen = 0;
  endtask

  // Waits (bounded) for ld_ack_o, returns ticks waited, then drops the request.
  task automatic wait_ack(input string tag, output int lat);
    lat = 0;
    while (!ld_ack && lat < 30) begin tick(1); lat++; end
    if (!ld_ack) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    ld_req = 0;
  endtask

  initial begin
    int lat;
    mem[18'h10000] = 8'h5A;
    clr_mon();

    // ---------------- reset values ----------------
    tick(3);
    check_val("rst_ce_n",     ce_n, 1);
    check_val("rst_oe_n",     oe_n, 1);
    check_val("rst_we_n",     we_n, 1);
    check_val("rst_addr",     sram_addr, 0);
    check_val("rst_bus_z",    sram_data, 8'hFF);
    check_val("rst_mcu_rd",   mcu_rddat, 0);
    check_val("rst_ld_rd",    ld_rddat, 0);
    check_val("rst_ack",      ld_ack, 0);
    check_val("rst_busy",     mcu_busy, 0);
    check_val("rst_ovf",      mcu_ovf, 0);
    rst = 0;
    tick(2);

    // ---------------- MCU data write, bank 1 ----------------
    clr_mon();
    mcu_drive(1, 0, 0, 16'h1234, 8'hA5, 1);
    tick(3);   // two synchroniser edges plus the start edge: now in SETUP
    check_val("wr_setup_ce",   ce_n, 0);
    check_val("wr_setup_we",   we_n, 1);
    check_val("wr_setup_addr", sram_addr, 18'h21234);
    check_val("wr_setup_bus",  sram_data, 8'hA5);
    check_val("wr_busy",       mcu_busy, 1);
    tick(1);
    check_val("wr_strobe_we",  we_n, 0);
    tick(6);
    mcu_release();
    tick(4);
    check_val("wr_we_cycles",  we_cnt, 3);
    check_val("wr_oe_cycles",  oe_cnt, 0);
    check_val("wr_len",        ce_cnt, 5);
    check_val("wr_accesses",   acc_cnt, 1);
    check_val("wr_busy_done",  mcu_busy, 0);

    // ---------------- MCU data read back ----------------
    clr_mon();
    mcu_drive(0, 1, 0, 16'h1234, 8'h00, 1);
    tick(10);
    mcu_release();
    tick(4);
    check_val("rd_oe_cycles",  oe_cnt, 3);
    check_val("rd_we_cycles",  we_cnt, 0);
    check_val("rd_addr",       log_addr[0], 18'h21234);
    check_val("rd_data",       mcu_rddat, 8'hA5);

    // ---------------- PSEN code fetch, bank 0 ----------------
    clr_mon();
    mcu_drive(0, 0, 1, 16'h0000, 8'h00, 0);
    tick(10);
    mcu_release();
    tick(4);
    check_val("psen_addr",     log_addr[0], 18'h10000);
    check_val("psen_oe",       oe_cnt, 3);
    check_val("psen_we",       we_cnt, 0);
    check_val("psen_bus_z",    drv_seen, 0);
    check_val("psen_data",     mcu_rddat, 8'h5A);

    // ---------------- Loader write then read ----------------
    clr_mon();
    ld_req = 1; ld_wr = 1; ld_addr = 18'h10005; ld_wrdat = 8'h3C;
    wait_ack("ldw", lat);
    // Request visible in IDLE cycle 1, SETUP cycle 2, STROBE 3..5, HOLD 6.
    check_val("ldw_latency",   lat, 5);
    tick(3);
    check_val("ldw_acks",      ack_cnt, 1);
    check_val("ldw_len",       ce_cnt, 5);
    check_val("ldw_we",        we_cnt, 3);
    clr_mon();
    ld_req = 1; ld_wr = 0; ld_wrdat = 8'h00;
    wait_ack("ldr", lat);
    tick(3);
    check_val("ldr_acks",      ack_cnt, 1);
    check_val("ldr_data",      ld_rddat, 8'h3C);
    check_val("ldr_len",       ce_cnt, 5);
    check_val("ldr_mcu_keep",  mcu_rddat, 8'h5A);

    // ---------------- Arbitration and overflow ----------------
    clr_mon();
    mcu_drive(1, 0, 0, 16'h0042, 8'h77, 0);
    tick(2);
    ld_req = 1; ld_wr = 0; ld_addr = 18'h10005;   // request meets the MCU edge
    tick(1);
    mcu_release();                                 // MCU access now in SETUP
    tick(1);
    mcu_drive(1, 0, 0, 16'h0042, 8'h77, 0);        // second edge lands mid-access
    wait_ack("arb", lat);
    mcu_release();
    tick(8);
    check_val("arb_first",     log_addr[0], 18'h00042);
    check_val("arb_second",    log_addr[1], 18'h10005);
    check_val("arb_gap",       log_gap[1], 1);
    check_val("arb_accesses",  acc_cnt, 2);
    check_val("arb_ovf",       mcu_ovf, 1);
    check_val("arb_ld_data",   ld_rddat, 8'h3C);
    check_val("arb_mem",       mem[18'h00042], 8'h77);

    // ---------------- Strobe held 20 cycles ----------------
    clr_mon();
    mcu_drive(0, 1, 0, 16'h0100, 8'h00, 1);
    tick(20);
    mcu_release();
    tick(4);
    check_val("hold_accesses", acc_cnt, 1);
    check_val("hold_oe",       oe_cnt, 3);
    check_val("no_overlap",    both_low, 0);

    // ---------------- Reset during write STROBE ----------------
    clr_mon();
    mcu_drive(1, 0, 0, 16'h0200, 8'hC3, 0);
    tick(4);
    check_val("rstw_we_low",   we_n, 0);
    #1 rst = 1;
    #1;
    check_val("rstw_we_n",     we_n, 1);
    check_val("rstw_ce_n",     ce_n, 1);
    check_val("rstw_oe_n",     oe_n, 1);
    check_val("rstw_bus_z",    sram_data, 8'hFF);
    check_val("rstw_addr",     sram_addr, 0);
    check_val("rstw_busy",     mcu_busy, 0);
    check_val("rstw_ovf",      mcu_ovf, 0);
    check_val("rstw_mcu_rd",   mcu_rddat, 0);
    check_val("rstw_ld_rd",    ld_rddat, 0);
    tick(3);
    mcu_release();
    check_val("rstw_no_ack",   ack_cnt, 0);
    check_val("rstw_ack",      ld_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
